// File: rtl/imem_responder_pkg.sv
// Shared types and defaults for the instruction-fetch responder.
// The FSM encoding and the memory-map defaults all live here.
package imem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] IMEM_BASE  = 32'h0000_3000;
  localparam int          IMEM_DEPTH = 4096;

  // Wait-state counter width; a zero-wait build still keeps a 1-bit counter.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch-stage <-> instruction-memory bus: request channel, response channel and redirect flush.
// Handshake: a beat moves on a rising edge where valid & ready are both high; the responder
// holds rsp_* stable while rsp_valid & !rsp_ready; a flush cycle voids any shown response.
interface imem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_pc;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_pc, rsp_err
  );
endinterface

// File: rtl/imem_responder_rom.sv
// Instruction word store with a registered read port.
// The write port exists only to load the program image before fetching starts.
module imem_rom
  import imem_responder_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [31:0]      data_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [31:0]      wr_data_i
);

  logic [31:0] rom_q [DEPTH];
  logic [31:0] data_q;

  // Read register only updates when enabled, so it doubles as the held response word.
  always_ff @(posedge clk) begin
    if (wr_en_i) rom_q[wr_idx_i] <= wr_data_i;
    if (en_i)    data_q <= rom_q[idx_i];
  end

  assign data_o = data_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: accepts word addresses, applies wait states, returns the
// instruction or an address fault, and drops in-flight work on flush.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IMEM_BASE,
  parameter int          DEPTH       = IMEM_DEPTH,
  parameter int          WAIT_CYCLES = 0,
  parameter int          IDX_W       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  imem_responder_if.slave  bus,
  input  logic             prog_en_i,
  input  logic [IDX_W-1:0] prog_idx_i,
  input  logic [31:0]      prog_data_i,
  output state_t           dbg_state_o
);

  localparam int              CNT_W    = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [31:0]     SPAN     = 32'(4 * DEPTH);
  localparam bit              NO_WAIT  = (WAIT_CYCLES == 0);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      addr_q;
  logic [31:0]      pc_q;
  logic             err_q;
  logic             valid_q;

  logic [31:0]      req_off;
  logic [31:0]      wait_off;
  logic             req_err;
  logic             accept;
  logic             wait_done;
  logic             rom_en;
  logic [IDX_W-1:0] rom_idx;
  logic [31:0]      rom_data;

  // Offset is only trusted once addr >= BASE_ADDR, so the top-of-range compare never wraps.
  assign req_off   = bus.req_addr - BASE_ADDR;
  assign wait_off  = addr_q - BASE_ADDR;
  assign req_err   = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr < BASE_ADDR) || (req_off >= SPAN);

  assign bus.req_ready = !bus.flush && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && bus.rsp_ready));
  assign accept        = bus.req_valid && bus.req_ready;
  assign wait_done     = (state_q == ST_WAIT) && (cnt_q == '0);

  // The ROM read fires on the same edge that enters RESP; faulting addresses never read.
  assign rom_en  = !bus.flush && ((accept && !req_err && NO_WAIT) || wait_done);
  assign rom_idx = accept ? IDX_W'(req_off >> 2) : IDX_W'(wait_off >> 2);

  imem_rom #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_rom (
    .clk       (clk),
    .en_i      (rom_en),
    .idx_i     (rom_idx),
    .data_o    (rom_data),
    .wr_en_i   (prog_en_i),
    .wr_idx_i  (prog_idx_i),
    .wr_data_i (prog_data_i)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else if (bus.flush) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else if (accept) begin
      if (req_err || NO_WAIT) begin
        state_q <= ST_RESP;
        valid_q <= 1'b1;
        pc_q    <= bus.req_addr;
        err_q   <= req_err;
      end else begin
        state_q <= ST_WAIT;
        cnt_q   <= CNT_LOAD;
        addr_q  <= bus.req_addr;
        valid_q <= 1'b0;
      end
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (cnt_q == '0) begin
            state_q <= ST_RESP;
            valid_q <= 1'b1;
            pc_q    <= addr_q;
            err_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid = valid_q;
  assign bus.rsp_pc    = pc_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_instr = (valid_q && !err_q) ? rom_data : 32'h0;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: a zero-wait and a three-wait instance side by side, directed
// scenarios plus a random stall/flush soak, responses checked in order against a model.
module tb_imem_responder;
  import imem_responder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid   [2];
  logic [31:0] req_addr    [2];
  logic        flush       [2];
  logic        rsp_ready   [2];
  logic        req_ready_w [2];
  logic        rsp_valid_w [2];
  logic [31:0] rsp_instr_w [2];
  logic [31:0] rsp_pc_w    [2];
  logic        rsp_err_w   [2];
  state_t      st_w        [2];

  logic        prog_en;
  logic [11:0] prog_idx;
  logic [31:0] prog_data;

  logic [31:0] img [4096];
  logic [64:0] exp_q0 [$];
  logic [64:0] exp_q1 [$];
  int n_checks = 0;
  int n_fail   = 0;

  imem_responder_if b0 ();
  imem_responder_if b3 ();

  assign b0.req_valid = req_valid[0];
  assign b0.req_addr  = req_addr[0];
  assign b0.flush     = flush[0];
  assign b0.rsp_ready = rsp_ready[0];
  assign req_ready_w[0] = b0.req_ready;
  assign rsp_valid_w[0] = b0.rsp_valid;
  assign rsp_instr_w[0] = b0.rsp_instr;
  assign rsp_pc_w[0]    = b0.rsp_pc;
  assign rsp_err_w[0]   = b0.rsp_err;

  assign b3.req_valid = req_valid[1];
  assign b3.req_addr  = req_addr[1];
  assign b3.flush     = flush[1];
  assign b3.rsp_ready = rsp_ready[1];
  assign req_ready_w[1] = b3.req_ready;
  assign rsp_valid_w[1] = b3.rsp_valid;
  assign rsp_instr_w[1] = b3.rsp_instr;
  assign rsp_pc_w[1]    = b3.rsp_pc;
  assign rsp_err_w[1]   = b3.rsp_err;

  imem_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk (clk), .reset (reset), .bus (b0),
    .prog_en_i (prog_en), .prog_idx_i (prog_idx), .prog_data_i (prog_data),
    .dbg_state_o (st_w[0])
  );

  imem_responder #(.WAIT_CYCLES(3)) u_dut3 (
    .clk (clk), .reset (reset), .bus (b3),
    .prog_en_i (prog_en), .prog_idx_i (prog_idx), .prog_data_i (prog_data),
    .dbg_state_o (st_w[1])
  );

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [64:0] model(input logic [31:0] a);
    logic [31:0] off;
    logic        e;
    off = a - 32'h0000_3000;
    e   = (a[1:0] != 2'b00) || (a < 32'h0000_3000) || (off >= 32'h0000_4000);
    return {e, a, (e ? 32'h0 : img[off[13:2]])};
  endfunction

  function automatic void q_push(input int k, input logic [64:0] v);
    if (k == 0) exp_q0.push_back(v); else exp_q1.push_back(v);
  endfunction

  function automatic logic [64:0] q_pop(input int k);
    if (k == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  function automatic int q_size(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic void q_clear(input int k);
    if (k == 0) exp_q0.delete(); else exp_q1.delete();
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset || flush[k]) begin
        q_clear(k);
      end else begin
        if (rsp_valid_w[k] && rsp_ready[k]) begin
          if (q_size(k) == 0)
            chk($sformatf("spurious_rsp%0d", k), rsp_valid_w[k], 1'b0);
          else
            chk($sformatf("rsp%0d", k), {rsp_err_w[k], rsp_pc_w[k], rsp_instr_w[k]}, q_pop(k));
        end
        if (req_valid[k] && req_ready_w[k]) q_push(k, model(req_addr[k]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input logic [31:0] a);
    bit ok;
    ok = 1'b0;
    req_valid[k] = 1'b1;
    req_addr[k]  = a;
    for (int n = 0; n < 50 && !ok; n++) begin
      @(negedge clk);
      ok = req_ready_w[k];
    end
    chk($sformatf("accept%0d_%h", k, a), ok, 1'b1);
    tick();
    req_valid[k] = 1'b0;
  endtask

  // Counts negedges from the cycle after the accept until rsp_valid shows.
  task automatic wait_rsp(input int k, input int exp_lat);
    int  n;
    bit  seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      seen = rsp_valid_w[k];
    end
    chk($sformatf("latency%0d", k), n, exp_lat);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] burst_tab [6];
  logic [31:0] err_tab   [3];
  logic [31:0] soak_tab  [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    burst_tab = '{32'h3008, 32'h300c, 32'h6ffc, 32'h7000, 32'h3001, 32'h3010};
    err_tab   = '{32'h3002, 32'h2ffc, 32'h7000};
    soak_tab  = '{32'h3000, 32'h3004, 32'h3008, 32'h303c, 32'h6ffc, 32'h3002, 32'h2ffc, 32'h7000};
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_addr[k] = '0; flush[k] = 1'b0; rsp_ready[k] = 1'b1;
    end
    for (int i = 0; i < 16; i++) img[i] = 32'h3c01_0001 + 32'(i) * 32'h100;
    img[4095] = 32'h0bad_f00d;

    // Image load while held in reset.
    prog_en = 1'b0; prog_idx = '0; prog_data = '0;
    tick();
    for (int i = 0; i < 17; i++) begin
      prog_en   = 1'b1;
      prog_idx  = (i == 16) ? 12'hfff : 12'(i);
      prog_data = img[(i == 16) ? 4095 : i];
      tick();
    end
    prog_en = 1'b0;

    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid%0d", k), rsp_valid_w[k], 1'b0);
      chk($sformatf("rst_state%0d", k), st_w[k], ST_IDLE);
      chk($sformatf("rst_pc%0d", k), rsp_pc_w[k], 32'h0);
      chk($sformatf("rst_err%0d", k), rsp_err_w[k], 1'b0);
      chk($sformatf("rst_instr%0d", k), rsp_instr_w[k], 32'h0);
    end
    tick();
    reset = 1'b0;
    tick();

    // 1: zero-wait fetch, back-to-back second request in the response cycle.
    req_valid[0] = 1'b1; req_addr[0] = 32'h3000;
    @(negedge clk);
    chk("t1_accept", req_ready_w[0], 1'b1);
    tick();
    req_addr[0] = 32'h3004;
    @(negedge clk);
    chk("t1_valid", rsp_valid_w[0], 1'b1);
    chk("t1_instr", rsp_instr_w[0], 32'h3c01_0001);
    chk("t1_pc", rsp_pc_w[0], 32'h3000);
    chk("t1_err", rsp_err_w[0], 1'b0);
    chk("t1_b2b_ready", req_ready_w[0], 1'b1);
    tick();
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("t1_pc2", rsp_pc_w[0], 32'h3004);
    chk("t1_instr2", rsp_instr_w[0], 32'h3c01_0101);
    tick();
    @(negedge clk);
    chk("t1_idle_valid", rsp_valid_w[0], 1'b0);
    tick();

    // Zero-wait burst, one request per cycle, including range edges.
    req_valid[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_addr[0] = burst_tab[i];
      @(negedge clk);
      chk("burst_ready", req_ready_w[0], 1'b1);
      tick();
    end
    req_valid[0] = 1'b0;
    repeat (3) tick();

    // 2: three wait states, then a 5-cycle consumer stall.
    rsp_ready[1] = 1'b0;
    issue(1, 32'h3008);
    wait_rsp(1, 4);
    tick();
    req_valid[1] = 1'b1; req_addr[1] = 32'h300c;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", rsp_valid_w[1], 1'b1);
      chk("t2_hold_pc", rsp_pc_w[1], 32'h3008);
      chk("t2_hold_instr", rsp_instr_w[1], 32'h3c01_0201);
      chk("t2_hold_ready", req_ready_w[1], 1'b0);
      tick();
    end
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    chk("t2_release_accept", req_ready_w[1], 1'b1);
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(1, 4);
    tick();

    // 3: faulting addresses answer in one cycle despite wait states.
    for (int i = 0; i < 3; i++) begin
      issue(1, err_tab[i]);
      wait_rsp(1, 1);
      chk("t3_err", rsp_err_w[1], 1'b1);
      chk("t3_instr", rsp_instr_w[1], 32'h0);
      tick();
    end

    // 4: flush two cycles after accept kills the fetch; next request answers normally.
    issue(1, 32'h3000);
    tick();
    flush[1] = 1'b1;
    @(negedge clk);
    chk("t4_flush_blocks", req_ready_w[1], 1'b0);
    tick();
    flush[1] = 1'b0;
    issue(1, 32'h3010);
    wait_rsp(1, 4);
    chk("t4_pc", rsp_pc_w[1], 32'h3010);
    tick();

    // 5: asynchronous reset mid-WAIT, with the other instance holding a response.
    rsp_ready[0] = 1'b0;
    issue(0, 32'h3008);
    issue(1, 32'h3004);
    #1;
    chk("t5_pre_wait", st_w[1], ST_WAIT);
    chk("t5_pre_hold", rsp_valid_w[0], 1'b1);
    #1;
    reset = 1'b1;
    #1;
    chk("t5_async_valid0", rsp_valid_w[0], 1'b0);
    chk("t5_async_valid1", rsp_valid_w[1], 1'b0);
    chk("t5_async_state1", st_w[1], ST_IDLE);
    chk("t5_async_state0", st_w[0], ST_IDLE);
    @(negedge clk);
    tick();
    reset = 1'b0;
    rsp_ready[0] = 1'b1;
    tick();
    issue(1, 32'h3000);
    wait_rsp(1, 4);
    chk("t5_word0", rsp_instr_w[1], 32'h3c01_0001);
    tick();

    // 6: random request / stall / flush soak on both instances.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        req_valid[k] = ($urandom_range(0, 3) != 0);
        req_addr[k]  = soak_tab[$urandom_range(0, 7)];
        rsp_ready[k] = ($urandom_range(0, 2) != 0);
        flush[k]     = ($urandom_range(0, 15) == 0);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; flush[k] = 1'b0; rsp_ready[k] = 1'b1;
    end
    repeat (10) tick();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("drain_q%0d", k), q_size(k), 0);
      chk($sformatf("drain_valid%0d", k), rsp_valid_w[k], 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
